fsk_tx_framer: RTL and testbench



---
 rtl/fsk_tx_framer_if.sv | 24 ++
 rtl/fsk_tx_framer.sv | 188 ++++++++++++++++++
 tb/tb_fsk_tx_framer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsk_tx_framer_if.sv
// Byte handshake between a data source and the FSK transmit framer.
//   tx_data  : byte to send (DATA_BITS wide), driven by the source
//   tx_valid : tx_data valid, driven by the source
//   tx_ready : framer holding register empty, driven by the framer
// A byte moves when tx_valid and tx_ready are both high on a mainclk edge.
interface fsk_tx_framer_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/fsk_tx_framer.sv
// Transmit-side UART-style framer with FSK modulation.
// Frames each byte as start(0), data LSB-first, optional even parity,
// stop(1) x STOP_BITS. One symbol is sent per clk288 period. The line
// symbol is modulated onto clk2 (mark, 1) or clk32 (space, 0).
// Ports:
//   mainclk   : system clock, all logic on its rising edge
//   reset     : asynchronous, active-low
//   clk2      : mark carrier, sampled as data
//   clk32     : space carrier, sampled as data
//   clk288    : symbol-rate clock, sampled as data; its rising edge is the symbol tick
//   tx_if     : byte handshake (slave side: tx_data, tx_valid in; tx_ready out)
//   bit_out   : current baseband line symbol
//   fsk_out   : modulated output, lags bit_out by one cycle
//   busy      : a frame is on the line
//   tx_done   : one-cycle pulse at the end of each frame's last stop symbol
//   frame_cnt : frames completed, wraps at 16 bits
module fsk_tx_framer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic           mainclk,
    input  logic           reset,
    input  logic           clk2,
    input  logic           clk32,
    input  logic           clk288,
    fsk_tx_framer_if.slave tx_if,
    output logic           bit_out,
    output logic           fsk_out,
    output logic           busy,
    output logic           tx_done,
    output logic [15:0]    frame_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY_EN != 32'sd0);

    state_t               state_r;
    logic                 clk288_q_r;
    logic                 tx_ready_r;   // holding register empty
    logic [DATA_BITS-1:0] hold_data_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic [3:0]           bit_cnt_r;
    logic                 bit_out_r;
    logic                 fsk_out_r;
    logic                 busy_r;
    logic                 tx_done_r;
    logic [15:0]          frame_cnt_r;

    logic                 sym_tick_s;
    logic                 accept_s;

    // Even parity over a data word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

    // Symbol tick on the rising edge of the sampled clk288; handshake when holding register is empty.
    always_comb begin
        sym_tick_s = clk288 & ~clk288_q_r;
        accept_s   = tx_if.tx_valid & tx_ready_r;
    end

    // Holding register, framing FSM, modulator and frame counter.
    always_ff @(posedge mainclk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            clk288_q_r  <= 1'b0;
            tx_ready_r  <= 1'b1;
            hold_data_r <= '0;
            shift_r     <= '0;
            parity_r    <= 1'b0;
            bit_cnt_r   <= 4'd0;
            bit_out_r   <= 1'b1;
            fsk_out_r   <= 1'b0;
            busy_r      <= 1'b0;
            tx_done_r   <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            clk288_q_r <= clk288;
            tx_done_r  <= 1'b0;
            // Carrier selected by the symbol currently on the line.
            fsk_out_r  <= bit_out_r ? clk2 : clk32;

            // Accept and loading are mutually exclusive: accept needs the
            // register empty, loading needs it full.
            if (accept_s) begin
                hold_data_r <= tx_if.tx_data;
                tx_ready_r  <= 1'b0;
            end else begin
                hold_data_r <= hold_data_r;
            end

            if (sym_tick_s) begin
                case (state_r)
                    IDLE: begin
                        if (!tx_ready_r) begin
                            shift_r    <= hold_data_r;
                            parity_r   <= even_parity(hold_data_r);
                            tx_ready_r <= 1'b1;
                            state_r    <= START;
                            bit_out_r  <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            bit_out_r  <= 1'b1;
                            busy_r     <= 1'b0;
                        end
                    end
                    START: begin
                        state_r   <= DATA;
                        bit_cnt_r <= 4'd0;
                        bit_out_r <= shift_r[0];
                    end
                    DATA: begin
                        shift_r <= shift_r >> 1;
                        if (bit_cnt_r == LAST_DATA) begin
                            bit_cnt_r <= 4'd0;
                            if (HAS_PARITY) begin
                                state_r   <= PARITY;
                                bit_out_r <= parity_r;
                            end else begin
                                state_r   <= STOP;
                                bit_out_r <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            bit_out_r <= shift_r[1];
                        end
                    end
                    PARITY: begin
                        state_r   <= STOP;
                        bit_cnt_r <= 4'd0;
                        bit_out_r <= 1'b1;
                    end
                    STOP: begin
                        if (bit_cnt_r == LAST_STOP) begin
                            tx_done_r   <= 1'b1;
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                            bit_cnt_r   <= 4'd0;
                            // A byte already waiting starts immediately, no idle mark gap.
                            if (!tx_ready_r) begin
                                shift_r    <= hold_data_r;
                                parity_r   <= even_parity(hold_data_r);
                                tx_ready_r <= 1'b1;
                                state_r    <= START;
                                bit_out_r  <= 1'b0;
                                busy_r     <= 1'b1;
                            end else begin
                                state_r    <= IDLE;
                                bit_out_r  <= 1'b1;
                                busy_r     <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            bit_out_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        bit_cnt_r <= 4'd0;
                        bit_out_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign tx_if.tx_ready = tx_ready_r;
    assign bit_out        = bit_out_r;
    assign fsk_out        = fsk_out_r;
    assign busy           = busy_r;
    assign tx_done        = tx_done_r;
    assign frame_cnt      = frame_cnt_r;

endmodule

// File: tb/tb_fsk_tx_framer.sv
// Directed bench for fsk_tx_framer: dut1 uses default parameters, dut2 has
// no parity and two stop bits. The upstream divider is modelled by a
// 0..575 counter: clk2 = cnt[0], clk32 = cnt[4], clk288 = (cnt >= 288).
// A symbol starts at the edge where cnt goes 288 -> 289, so symbols are
// sampled at cnt == 0 (mid-symbol) on the falling edge.
module tb_fsk_tx_framer;

    logic        mainclk = 1'b0;
    logic        reset   = 1'b0;
    logic [9:0]  cnt     = 10'd0;
    logic        clk2, clk32, clk288;
    logic        prev_clk2 = 1'b0;
    logic        prev_clk32 = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          start_cyc;

    logic        bit_out1, fsk_out1, busy1, tx_done1;
    logic        bit_out2, fsk_out2, busy2, tx_done2;
    logic [15:0] frame_cnt1, frame_cnt2;

    fsk_tx_framer_if #(.DATA_BITS(8)) if1 ();
    fsk_tx_framer_if #(.DATA_BITS(8)) if2 ();

    fsk_tx_framer dut1 (
        .mainclk(mainclk), .reset(reset), .clk2(clk2), .clk32(clk32), .clk288(clk288),
        .tx_if(if1.slave), .bit_out(bit_out1), .fsk_out(fsk_out1), .busy(busy1),
        .tx_done(tx_done1), .frame_cnt(frame_cnt1)
    );

    fsk_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .mainclk(mainclk), .reset(reset), .clk2(clk2), .clk32(clk32), .clk288(clk288),
        .tx_if(if2.slave), .bit_out(bit_out2), .fsk_out(fsk_out2), .busy(busy2),
        .tx_done(tx_done2), .frame_cnt(frame_cnt2)
    );

    always #5 mainclk = ~mainclk;

    assign clk2   = cnt[0];
    assign clk32  = cnt[4];
    assign clk288 = (cnt >= 10'd288);

    always @(posedge mainclk) begin
        cnt        <= (cnt == 10'd575) ? 10'd0 : cnt + 10'd1;
        prev_clk2  <= clk2;
        prev_clk32 <= clk32;
        cyc        <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge mainclk);
            n++;
        end while (int'(cnt) != v && n < 1200);
        checks++;
        assert (int'(cnt) == v) else begin
            errors++;
            $error("FAIL wait_cnt observed=%0d expected=%0d", cnt, v);
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        int   n = 0;
        logic acc = 1'b0;
        if (sel) begin
            if2.tx_data = d; if2.tx_valid = 1'b1;
        end else begin
            if1.tx_data = d; if1.tx_valid = 1'b1;
        end
        while (!acc && n < 1500) begin
            acc = sel ? if2.tx_ready : if1.tx_ready;
            @(negedge mainclk);
            n++;
        end
        if1.tx_valid = 1'b0;
        if2.tx_valid = 1'b0;
        check("push_accepted", {31'd0, acc}, 32'd1);
    endtask

    // Samples n consecutive symbols at mid-symbol; seq[k] is symbol k.
    task automatic run_seq(input bit sel, input string tag, input logic [10:0] seq, input int n);
        for (int k = 0; k < n; k++) begin
            wait_cnt(0);
            check($sformatf("%s_sym%0d", tag, k), {31'd0, sel ? bit_out2 : bit_out1}, {31'd0, seq[k]});
        end
    endtask

    task automatic do_reset();
        @(negedge mainclk);
        reset = 1'b0;
        repeat (3) @(negedge mainclk);
        reset = 1'b1;
    endtask

    initial begin
        if1.tx_data = 8'h00; if1.tx_valid = 1'b0;
        if2.tx_data = 8'h00; if2.tx_valid = 1'b0;

        // ---- reset state and long idle ----
        repeat (2) @(negedge mainclk);
        check("rst_tx_ready", {31'd0, if1.tx_ready}, 32'd1);
        check("rst_bit_out",  {31'd0, bit_out1}, 32'd1);
        check("rst_fsk_out",  {31'd0, fsk_out1}, 32'd0);
        check("rst_busy",     {31'd0, busy1}, 32'd0);
        check("rst_tx_done",  {31'd0, tx_done1}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt1}, 32'd0);
        reset = 1'b1;
        repeat (2000) @(negedge mainclk);
        check("idle_bit_out",   {31'd0, bit_out1}, 32'd1);
        check("idle_tx_ready",  {31'd0, if1.tx_ready}, 32'd1);
        check("idle_busy",      {31'd0, busy1}, 32'd0);
        check("idle_frame_cnt", {16'd0, frame_cnt1}, 32'd0);
        check("idle_busy2",     {31'd0, busy2}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge mainclk);
            check("idle_fsk_clk2", {31'd0, fsk_out1}, {31'd0, prev_clk2});
        end

        // ---- 0xA5, defaults: 0,1,0,1,0,0,1,0,1,0,1 ----
        wait_cnt(100);
        push(1'b0, 8'hA5);
        check("a5_held_ready", {31'd0, if1.tx_ready}, 32'd0);
        wait_cnt(288);
        check("a5_pre_tick_busy", {31'd0, busy1}, 32'd0);
        check("a5_pre_tick_bit",  {31'd0, bit_out1}, 32'd1);
        wait_cnt(289);
        check("a5_start_busy",  {31'd0, busy1}, 32'd1);
        check("a5_start_bit",   {31'd0, bit_out1}, 32'd0);
        check("a5_start_ready", {31'd0, if1.tx_ready}, 32'd1);
        start_cyc = cyc;
        run_seq(1'b0, "a5", 11'b10101001010, 11);
        wait_cnt(288);
        check("a5_last_busy", {31'd0, busy1}, 32'd1);
        check("a5_last_done", {31'd0, tx_done1}, 32'd0);
        wait_cnt(289);
        check("a5_done",      {31'd0, tx_done1}, 32'd1);
        check("a5_busy_low",  {31'd0, busy1}, 32'd0);
        check("a5_frame_cnt", {16'd0, frame_cnt1}, 32'd1);
        check("a5_frame_len", cyc - start_cyc, 32'd6336);
        @(negedge mainclk);
        check("a5_done_pulse", {31'd0, tx_done1}, 32'd0);

        // ---- 0x3C then 0xFF back to back ----
        do_reset();
        wait_cnt(100);
        push(1'b0, 8'h3C);
        check("b2b_ready_full", {31'd0, if1.tx_ready}, 32'd0);
        push(1'b0, 8'hFF);
        check("b2b_ff_accept_cnt", {22'd0, cnt}, 32'd290);
        check("b2b_ready_held", {31'd0, if1.tx_ready}, 32'd0);
        run_seq(1'b0, "f3c", 11'b10001111000, 11);
        wait_cnt(288);
        check("b2b_ready_pre", {31'd0, if1.tx_ready}, 32'd0);
        wait_cnt(289);
        check("b2b_done1",  {31'd0, tx_done1}, 32'd1);
        check("b2b_cnt1",   {16'd0, frame_cnt1}, 32'd1);
        check("b2b_busy",   {31'd0, busy1}, 32'd1);
        check("b2b_start2", {31'd0, bit_out1}, 32'd0);
        check("b2b_ready_loaded", {31'd0, if1.tx_ready}, 32'd1);
        run_seq(1'b0, "fff", 11'b10111111110, 11);
        wait_cnt(289);
        check("b2b_done2",  {31'd0, tx_done1}, 32'd1);
        check("b2b_cnt2",   {16'd0, frame_cnt1}, 32'd2);
        check("b2b_idle",   {31'd0, busy1}, 32'd0);

        // ---- dut2: no parity, two stops, 0x01 ----
        wait_cnt(100);
        push(1'b1, 8'h01);
        wait_cnt(289);
        check("np_start_busy", {31'd0, busy2}, 32'd1);
        for (int k = 0; k < 11; k++) begin
            wait_cnt(0);
            check($sformatf("np_sym%0d", k), {31'd0, bit_out2}, {31'd0, 11'b11000000010 >> k} & 32'd1);
            if (k == 2) begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge mainclk);
                    check("np_space_clk32", {31'd0, fsk_out2}, {31'd0, prev_clk32});
                end
            end else if (k == 1) begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge mainclk);
                    check("np_mark_clk2", {31'd0, fsk_out2}, {31'd0, prev_clk2});
                end
            end else begin
                check("np_no_done", {31'd0, tx_done2}, 32'd0);
            end
        end
        wait_cnt(289);
        check("np_done",  {31'd0, tx_done2}, 32'd1);
        check("np_cnt",   {16'd0, frame_cnt2}, 32'd1);
        check("np_idle",  {31'd0, busy2}, 32'd0);

        // ---- reset during data bit 4 of 0x55, second byte held ----
        do_reset();
        wait_cnt(100);
        push(1'b0, 8'h55);
        push(1'b0, 8'h0F);
        run_seq(1'b0, "f55", 11'b00000101010, 6);
        reset = 1'b0;
        #1;
        check("mid_rst_bit",   {31'd0, bit_out1}, 32'd1);
        check("mid_rst_fsk",   {31'd0, fsk_out1}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy1}, 32'd0);
        check("mid_rst_ready", {31'd0, if1.tx_ready}, 32'd1);
        check("mid_rst_done",  {31'd0, tx_done1}, 32'd0);
        check("mid_rst_cnt",   {16'd0, frame_cnt1}, 32'd0);
        @(negedge mainclk);
        reset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_cnt(289);
            check("post_rst_bit",   {31'd0, bit_out1}, 32'd1);
            check("post_rst_busy",  {31'd0, busy1}, 32'd0);
            check("post_rst_ready", {31'd0, if1.tx_ready}, 32'd1);
        end

        // ---- frame counter wrap ----
        @(negedge mainclk);
        force dut1.frame_cnt_r = 16'hFFFF;
        @(negedge mainclk);
        release dut1.frame_cnt_r;
        @(negedge mainclk);
        check("wrap_preset", {16'd0, frame_cnt1}, 32'h0000FFFF);
        wait_cnt(100);
        push(1'b0, 8'h00);
        wait_cnt(289);
        check("wrap_start_busy", {31'd0, busy1}, 32'd1);
        run_seq(1'b0, "f00", 11'b10000000000, 11);
        wait_cnt(289);
        check("wrap_done", {31'd0, tx_done1}, 32'd1);
        check("wrap_cnt",  {16'd0, frame_cnt1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
